// File: rtl/aes_rounds_ctrl_pkg.sv
// Shared types and constants for the AES rounds sequencer: state encoding,
// round-count derivation from key width, and datapath mux select values.
package aes_rounds_pkg;

    localparam int ROUND_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_e;

    localparam logic SEL_INPUT    = 1'b0;
    localparam logic SEL_FEEDBACK = 1'b1;
    localparam logic SEL_FULL     = 1'b0;
    localparam logic SEL_FINAL    = 1'b1;

    function automatic int nr_of(input int key_width);
        case (key_width)
            256:     return 14;
            192:     return 12;
            default: return 10;
        endcase
    endfunction

endpackage

// File: rtl/aes_rounds_ctrl_if.sv
// Block-level valid/ready handshake between the AES source/sink and the rounds sequencer.
interface aes_rounds_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (output in_valid, output out_ready, input in_ready, input out_valid);
    modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/aes_round_counter.sv
// Round counter for the AES sequencer: clear/load-one/increment/hold, saturating at NR,
// with terminal flags for the last full round and the final round.
module aes_round_counter #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic               inc,
    output logic [ROUND_W-1:0] count,
    output logic               last_round,
    output logic               final_rnd
);
    localparam logic [ROUND_W-1:0] NR_W   = ROUND_W'(NR);
    localparam logic [ROUND_W-1:0] LAST_W = ROUND_W'(NR - 1);

    logic [ROUND_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = ROUND_W'(1);
        end else if (inc && (count_q != NR_W)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign last_round = (count_q == LAST_W);
    assign final_rnd  = (count_q == NR_W);
endmodule

// File: rtl/aes_rounds_ctrl.sv
// Iterative AES rounds sequencer: drives FF1/FF2 enables, round mux selects and round-key index.
// Optional macro AES_ROUNDS_CTRL_ABORT_EN adds an abort input that discards the block in flight.
module aes_rounds_ctrl
    import aes_rounds_pkg::*;
#(
    parameter int KEY_WIDTH = 128,
    parameter int ROUND_W   = aes_rounds_pkg::ROUND_W
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_rounds_ctrl_if.slave   hs,
    input  logic               key_ready,
`ifdef AES_ROUNDS_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic [ROUND_W-1:0] round_idx,
    output logic               FF1_enable_comp,
    output logic               FF2_enable,
    output logic               rounds_MUX1,
    output logic               rounds_MUX2,
    output logic               busy
);
    localparam int NR = nr_of(KEY_WIDTH);

    state_e             state_q, state_d;
    logic               cnt_clr, cnt_load, cnt_inc;
    logic [ROUND_W-1:0] count;
    logic               last_round, final_rnd;
    logic               abort_w;
    logic               in_ready_w, out_valid_w, accept;

`ifdef AES_ROUNDS_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    aes_round_counter #(
        .NR      (NR),
        .ROUND_W (ROUND_W)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .load       (cnt_load),
        .inc        (cnt_inc),
        .count      (count),
        .last_round (last_round),
        .final_rnd  (final_rnd)
    );

    // in_ready is gated by rst_n so nothing is accepted while reset is held
    assign in_ready_w = rst_n & key_ready & ~abort_w &
                        ((state_q == IDLE) | ((state_q == DONE) & hs.out_ready));
    assign accept     = hs.in_valid & in_ready_w;

    always_comb begin
        state_d         = state_q;
        cnt_clr         = 1'b0;
        cnt_load        = 1'b0;
        cnt_inc         = 1'b0;
        FF1_enable_comp = 1'b1;
        FF2_enable      = 1'b0;
        rounds_MUX1     = SEL_INPUT;
        rounds_MUX2     = SEL_FULL;
        round_idx       = count;
        out_valid_w     = 1'b0;
        busy            = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    FF1_enable_comp = 1'b0;
                    round_idx       = '0;
                    cnt_load        = 1'b1;
                    state_d         = ROUND;
                end
            end
            ROUND: begin
                busy        = 1'b1;
                rounds_MUX1 = SEL_FEEDBACK;
                if (abort_w) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (key_ready) begin
                    FF1_enable_comp = 1'b0;
                    cnt_inc         = 1'b1;
                    if (last_round) state_d = FINAL;
                end
            end
            FINAL: begin
                busy        = 1'b1;
                rounds_MUX1 = SEL_FEEDBACK;
                rounds_MUX2 = SEL_FINAL;
                if (abort_w || !final_rnd) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (key_ready) begin
                    FF2_enable = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                out_valid_w = ~abort_w;
                if (abort_w) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (hs.out_ready) begin
                    // consumed block with no acceptable successor falls back to IDLE
                    if (accept) begin
                        FF1_enable_comp = 1'b0;
                        round_idx       = '0;
                        cnt_load        = 1'b1;
                        state_d         = ROUND;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign hs.in_ready  = in_ready_w;
    assign hs.out_valid = out_valid_w;
endmodule

// File: tb/tb_aes_rounds_ctrl.sv
// Bench for aes_rounds_ctrl: AES-128/192/256 instances share stimulus and are compared
// every cycle against a block-level model (rounds done / result pending).
module tb_aes_rounds_ctrl;
    localparam int NINST = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic key_ready = 1'b0;

    logic [10:0] obs [NINST];

    bit m_has  [NINST];
    int m_done [NINST];
    bit m_pend [NINST];
    int first_ov [NINST];
    int cyc = 0;
    int t_acc = 0;
    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        aes_rounds_ctrl_if u_if ();
        logic [3:0] idx;
        logic ff1c, ff2, m1, m2, bz;
        assign u_if.in_valid  = in_valid;
        assign u_if.out_ready = out_ready;
        aes_rounds_ctrl #(.KEY_WIDTH(128 + 64 * g), .ROUND_W(4)) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .hs              (u_if),
            .key_ready       (key_ready),
`ifdef AES_ROUNDS_CTRL_ABORT_EN
            .abort           (1'b0),
`endif
            .round_idx       (idx),
            .FF1_enable_comp (ff1c),
            .FF2_enable      (ff2),
            .rounds_MUX1     (m1),
            .rounds_MUX2     (m2),
            .busy            (bz)
        );
        assign obs[g] = {u_if.in_ready, u_if.out_valid, bz, ff1c, ff2, m1, m2, idx};
    end

    // AES: Nr = Nk + 6 with Nk = key bits / 32
    function automatic int nr_ref(int i);
        return (128 + 64 * i) / 32 + 6;
    endfunction

    function automatic bit ref_ir(int i);
        return rst_n && key_ready && (m_pend[i] ? out_ready : !m_has[i]);
    endfunction

    function automatic logic [10:0] ref_out(int i);
        int nr;
        logic ir, ov, bz, f1, f2, m1, m2;
        logic [3:0] idx;
        nr = nr_ref(i);
        ir = 1'b0; ov = 1'b0; bz = 1'b0; f1 = 1'b1; f2 = 1'b0; m1 = 1'b0; m2 = 1'b0;
        idx = 4'd0;
        if (!rst_n) return {ir, ov, bz, f1, f2, m1, m2, idx};
        ir = ref_ir(i);
        if (m_pend[i]) begin
            ov  = 1'b1;
            idx = 4'(nr);
        end else if (m_has[i]) begin
            bz  = 1'b1;
            m1  = 1'b1;
            idx = 4'(m_done[i] + 1);
            m2  = (m_done[i] + 1 == nr);
            if (key_ready) begin
                if (m_done[i] + 1 < nr) f1 = 1'b0;
                else f2 = 1'b1;
            end
        end
        if (in_valid && ir) begin
            f1  = 1'b0;
            m1  = 1'b0;
            idx = 4'd0;
        end
        return {ir, ov, bz, f1, f2, m1, m2, idx};
    endfunction

    task automatic ref_update();
        for (int i = 0; i < NINST; i++) begin
            bit acc;
            acc = in_valid && ref_ir(i);
            if (!rst_n) begin
                m_has[i] = 0; m_pend[i] = 0; m_done[i] = 0;
            end else begin
                if (m_has[i] && key_ready) begin
                    m_done[i]++;
                    if (m_done[i] == nr_ref(i)) begin
                        m_has[i]  = 0;
                        m_pend[i] = 1;
                    end
                end else if (m_pend[i] && out_ready) begin
                    m_pend[i] = 0;
                end
                if (acc) begin
                    m_has[i] = 1; m_done[i] = 0; m_pend[i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NINST; i++) begin
            logic [10:0] e;
            e = ref_out(i);
            n_vec++;
            assert (obs[i] === e) else begin
                n_mis++;
                $error("FAIL ctl%0d cyc=%0d observed=%h expected=%h", i, cyc, obs[i], e);
            end
            if (obs[i][9] === 1'b1 && first_ov[i] < 0 && cyc > t_acc) first_ov[i] = cyc;
        end
        ref_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic accept_block();
        in_valid  = 1'b1;
        key_ready = 1'b1;
        for (int i = 0; i < NINST; i++) first_ov[i] = -1;
        t_acc = cyc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_lat(int extra);
        for (int i = 0; i < NINST; i++) begin
            n_vec++;
            assert (first_ov[i] - t_acc === nr_ref(i) + 1 + extra) else begin
                n_mis++;
                $error("FAIL latency%0d observed=%0d expected=%0d", i, first_ov[i] - t_acc,
                       nr_ref(i) + 1 + extra);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NINST; i++) first_ov[i] = -1;
        // reset held with a block offered: nothing may be accepted
        rst_n = 1'b0; key_ready = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        steps(2);
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();

        // single block, no stalls
        accept_block();
        steps(16);
        check_lat(0);

        // key_ready low for 3 cycles while round 5 is presented
        accept_block();
        steps(4);
        key_ready = 1'b0;
        steps(3);
        key_ready = 1'b1;
        steps(15);
        check_lat(3);

        // sink back-pressure in DONE, then back-to-back accept
        out_ready = 1'b0;
        accept_block();
        steps(15);
        steps(4);
        out_ready = 1'b1;
        accept_block();
        steps(16);
        check_lat(0);

        // reset during round 6 discards the block
        accept_block();
        steps(5);
        rst_n = 1'b0;
        steps(2);
        rst_n = 1'b1;
        steps(2);
        accept_block();
        steps(16);
        check_lat(0);

        // randomized traffic with occasional reset pulses
        for (int k = 0; k < 600; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            key_ready = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
